// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgen_pkg.sv
// Shared types and constants for the programmable glitch-free clock divider.
package gf180mcu_fd_sc_mcu9t5v0__clkgen_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int RST_DIV   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgen_div_ld.sv
// Pending-divisor capture and apply qualification for the clock divider.
// A later LOAD overwrites an unapplied one, so at most one ack per apply.
module gf180mcu_fd_sc_mcu9t5v0__clkgen_div_ld
  import gf180mcu_fd_sc_mcu9t5v0__clkgen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             in_idle,
  input  logic             fall_edge,
  output logic             apply,
  output logic [DIV_W-1:0] pend_val
);

  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;

  assign apply    = pend_v_q & (in_idle | fall_edge);
  assign pend_val = pend_q;

  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (apply) begin
      pend_v_d = 1'b0;
    end
    // A capture coinciding with an apply re-arms with the newer value.
    if (load) begin
      pend_d   = div;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgen_div.sv
// Programmable even-ratio clock divider with clean start/stop and
// runt-free divisor switching on the falling toggle of Z.
module gf180mcu_fd_sc_mcu9t5v0__clkgen_div
  import gf180mcu_fd_sc_mcu9t5v0__clkgen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  output logic             LOAD_ACK,
  output logic             ACTIVE,
  output logic             Z
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             z_q, z_d;
  logic             ack_q, ack_d;
  logic             active_q, active_d;

  logic             cnt_hit;
  logic             in_idle;
  logic             fall_edge;
  logic             apply;
  logic [DIV_W-1:0] pend_val;

  assign cnt_hit   = (cnt_q == div_q);
  assign in_idle   = (state_q == ST_IDLE);
  // Every high->low toggle of Z, whether running or stopping.
  assign fall_edge = !in_idle && z_q && cnt_hit;

  gf180mcu_fd_sc_mcu9t5v0__clkgen_div_ld #(
    .DIV_W (DIV_W)
  ) u_ld (
    .clk       (CLK),
    .rn        (RN),
    .load      (LOAD),
    .div       (DIV),
    .in_idle   (in_idle),
    .fall_edge (fall_edge),
    .apply     (apply),
    .pend_val  (pend_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        z_d   = 1'b0;
        if (EN) begin
          state_d = ST_RUN;
          z_d     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!EN && !z_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_hit) begin
          // With EN low, z_q is high here, so this is the final fall.
          z_d   = ~z_q;
          cnt_d = '0;
          if (!EN) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!EN) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_hit) begin
          z_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        z_d     = 1'b0;
      end
    endcase
    div_d    = apply ? pend_val : div_q;
    ack_d    = apply;
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_W'(RST_DIV);
      z_q      <= 1'b0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      z_q      <= z_d;
      ack_q    <= ack_d;
      active_q <= active_d;
    end
  end

  assign Z        = z_q;
  assign LOAD_ACK = ack_q;
  assign ACTIVE   = active_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkgen_div.sv
// Directed self-checking bench for the clock divider; expected Z/ACK/ACTIVE
// sequences are hand-derived from the half-period = DIV+1 rule.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkgen_div;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rn;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             load;
  logic             load_ack;
  logic             active;
  logic             z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__clkgen_div #(
    .DIV_W (DIV_W)
  ) dut (
    .CLK      (clk),
    .RN       (rn),
    .EN       (en),
    .DIV      (div),
    .LOAD     (load),
    .LOAD_ACK (load_ack),
    .ACTIVE   (active),
    .Z        (z)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic zexp, input logic ackexp);
    step();
    check_val({tag, ".z"}, 32'(z), 32'(zexp));
    check_val({tag, ".ack"}, 32'(load_ack), 32'(ackexp));
  endtask

  initial begin
    rn = 1'b0; en = 1'b0; div = '0; load = 1'b0;
    step(); step();
    check_val("rst.z", 32'(z), 32'd0);
    check_val("rst.active", 32'(active), 32'd0);
    check_val("rst.ack", 32'(load_ack), 32'd0);

    // Divide-by-2 from reset divisor 0.
    rn = 1'b1; en = 1'b1;
    step();
    check_val("d2.start_active", 32'(active), 32'd1);
    check_val("d2.start_z", 32'(z), 32'd1);
    step_chk("d2.c1", 1'b0, 1'b0);
    step_chk("d2.c2", 1'b1, 1'b0);
    step_chk("d2.c3", 1'b0, 1'b0);
    step_chk("d2.c4", 1'b1, 1'b0);
    step_chk("d2.c5", 1'b0, 1'b0);
    en = 1'b0;
    step();
    check_val("d2.stop_low_active", 32'(active), 32'd0);
    check_val("d2.stop_low_z", 32'(z), 32'd0);

    // LOAD DIV=3 in IDLE: ack one edge after capture.
    load = 1'b1; div = 8'd3;
    step_chk("ld3.cap", 1'b0, 1'b0);
    load = 1'b0;
    step_chk("ld3.apply", 1'b0, 1'b1);
    step_chk("ld3.after", 1'b0, 1'b0);
    en = 1'b1;
    step_chk("p8.h0", 1'b1, 1'b0);
    step_chk("p8.h1", 1'b1, 1'b0);
    step_chk("p8.h2", 1'b1, 1'b0);
    step_chk("p8.h3", 1'b1, 1'b0);
    step_chk("p8.l0", 1'b0, 1'b0);
    step_chk("p8.l1", 1'b0, 1'b0);
    step_chk("p8.l2", 1'b0, 1'b0);
    step_chk("p8.l3", 1'b0, 1'b0);
    step_chk("p8.h0b", 1'b1, 1'b0);

    // Mid-high LOAD DIV=1: high completes at 4, low becomes 2.
    load = 1'b1; div = 8'd1;
    step_chk("sw1.h1", 1'b1, 1'b0);
    load = 1'b0;
    step_chk("sw1.h2", 1'b1, 1'b0);
    step_chk("sw1.h3", 1'b1, 1'b0);
    step_chk("sw1.fall", 1'b0, 1'b1);
    step_chk("sw1.l1", 1'b0, 1'b0);
    step_chk("sw1.h0", 1'b1, 1'b0);
    step_chk("sw1.h1b", 1'b1, 1'b0);
    step_chk("sw1.l0", 1'b0, 1'b0);
    step_chk("sw1.l1b", 1'b0, 1'b0);

    // Back to DIV=3, then stop on the 2nd high cycle.
    load = 1'b1; div = 8'd3;
    step_chk("sw3.h0", 1'b1, 1'b0);
    load = 1'b0;
    step_chk("sw3.h1", 1'b1, 1'b0);
    step_chk("sw3.fall", 1'b0, 1'b1);
    step_chk("sw3.l1", 1'b0, 1'b0);
    step_chk("sw3.l2", 1'b0, 1'b0);
    step_chk("sw3.l3", 1'b0, 1'b0);
    step_chk("sw3.h0", 1'b1, 1'b0);
    step_chk("sw3.h1", 1'b1, 1'b0);
    en = 1'b0;
    step_chk("stop.h2", 1'b1, 1'b0);
    check_val("stop.h2_active", 32'(active), 32'd1);
    en = 1'b1;
    step_chk("stop.h3", 1'b1, 1'b0);
    check_val("stop.h3_active", 32'(active), 32'd1);
    step_chk("stop.idle", 1'b0, 1'b0);
    check_val("stop.idle_active", 32'(active), 32'd0);
    step_chk("restart", 1'b1, 1'b0);
    check_val("restart.active", 32'(active), 32'd1);

    // Two LOADs before the fall: single ack, ratio 2 applied.
    load = 1'b1; div = 8'd5;
    step_chk("dbl.h1", 1'b1, 1'b0);
    div = 8'd2;
    step_chk("dbl.h2", 1'b1, 1'b0);
    load = 1'b0;
    step_chk("dbl.h3", 1'b1, 1'b0);
    step_chk("dbl.fall", 1'b0, 1'b1);
    step_chk("dbl.l1", 1'b0, 1'b0);
    step_chk("dbl.l2", 1'b0, 1'b0);
    step_chk("dbl.h0", 1'b1, 1'b0);
    step_chk("dbl.h1b", 1'b1, 1'b0);
    step_chk("dbl.h2b", 1'b1, 1'b0);
    step_chk("dbl.fallb", 1'b0, 1'b0);
    step_chk("dbl.l1b", 1'b0, 1'b0);
    step_chk("dbl.l2b", 1'b0, 1'b0);
    step_chk("dbl.h0c", 1'b1, 1'b0);

    // Reset mid-high with a pending load: pending discarded, div back to 0.
    load = 1'b1; div = 8'd7;
    step_chk("rsth.h1", 1'b1, 1'b0);
    load = 1'b0; rn = 1'b0;
    step_chk("rsth.rst", 1'b0, 1'b0);
    check_val("rsth.active", 32'(active), 32'd0);
    rn = 1'b1; en = 1'b0;
    step_chk("rsth.noack", 1'b0, 1'b0);
    en = 1'b1;
    step_chk("rsth.d2a", 1'b1, 1'b0);
    step_chk("rsth.d2b", 1'b0, 1'b0);
    step_chk("rsth.d2c", 1'b1, 1'b0);

    // Stop from high with cnt==div: falls and idles on the same edge.
    en = 1'b0;
    step_chk("maxs.idle", 1'b0, 1'b0);
    check_val("maxs.active", 32'(active), 32'd0);

    // Maximum divisor: 256-cycle phases.
    load = 1'b1; div = 8'hFF;
    step();
    load = 1'b0;
    step_chk("max.ack", 1'b0, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
      check_val("max.high", 32'(z), 32'd1);
    end
    for (int i = 0; i < 256; i++) begin
      step();
      check_val("max.low", 32'(z), 32'd0);
    end
    step();
    check_val("max.rise", 32'(z), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
